sample_ram_read_arbiter: RTL and testbench

- Shares the single read port of the 4096-entry capture sample RAM between two requesters.
- Requester 1 is the Nios II, which supplies the 12-bit address through the read-address PIO and issues single reads.
- Requester 2 is an auto-scan sequencer that streams a contiguous, circular address window to the harmonic/DFT engine.
- Tags every issued read so returned data reaches the correct consumer after the fixed RAM latency.

---
 rtl/sample_ram_pkg.sv | 25 ++
 rtl/sample_ram_read_arbiter_if.sv | 56 +++++
 rtl/sample_ram_read_arbiter_read_tag_pipe.sv | 42 ++++
 rtl/sample_ram_read_arbiter.sv | 143 ++++++++++++++
 tb/tb_sample_ram_read_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sample_ram_pkg.sv
// Shared types for the sample RAM read arbiter: default widths, scan FSM states,
// read owner encoding and the per-read tag carried alongside the RAM latency.
package sample_ram_pkg;

  localparam int DEFAULT_ADDR_W = 12;
  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_RD_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_t;

  typedef enum logic {
    OWNER_CPU  = 1'b0,
    OWNER_SCAN = 1'b1
  } owner_t;

  typedef struct packed {
    logic   valid;
    owner_t owner;
  } read_tag_t;

endpackage

// File: rtl/sample_ram_read_arbiter_if.sv
// Request/response and RAM read-port bundle of the sample RAM read arbiter.
// SAMPLE_RAM_ARB_STRIDE_EN adds the scan_stride input.
interface sample_ram_read_arbiter_if
  import sample_ram_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W
) ();

  // Handshake semantics: every *_req/*_start/*_abort input is a one-cycle strobe
  // accepted unconditionally (no ready/backpressure); every *_valid/*_done output
  // is a one-cycle pulse qualifying its data, which is held until overwritten.
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_req;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_rdata_valid;

  logic              scan_start;
  logic              scan_abort;
  logic              scan_hold;
  logic [ADDR_W-1:0] scan_base;
  logic [ADDR_W:0]   scan_len;
`ifdef SAMPLE_RAM_ARB_STRIDE_EN
  logic [ADDR_W-1:0] scan_stride;
`endif
  logic [DATA_W-1:0] scan_data;
  logic              scan_data_valid;
  logic              scan_busy;
  logic              scan_done;
  scan_state_t       scan_state;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
`ifdef SAMPLE_RAM_ARB_STRIDE_EN
    input  scan_stride,
`endif
    input  cpu_addr, cpu_req, scan_start, scan_abort, scan_hold,
    input  scan_base, scan_len, ram_rdata,
    output cpu_rdata, cpu_rdata_valid, scan_data, scan_data_valid,
    output scan_busy, scan_done, scan_state, ram_addr, ram_rden
  );

  modport master (
`ifdef SAMPLE_RAM_ARB_STRIDE_EN
    output scan_stride,
`endif
    output cpu_addr, cpu_req, scan_start, scan_abort, scan_hold,
    output scan_base, scan_len, ram_rdata,
    input  cpu_rdata, cpu_rdata_valid, scan_data, scan_data_valid,
    input  scan_busy, scan_done, scan_state, ram_addr, ram_rden
  );

endinterface

// File: rtl/sample_ram_read_arbiter_read_tag_pipe.sv
// RD_LAT-deep shift register of read tags, aligned so out_tag describes the
// ram_rdata currently presented by the RAM.
module read_tag_pipe
  import sample_ram_pkg::*;
#(
  parameter int RD_LAT = DEFAULT_RD_LAT
) (
  input  logic      clk,
  input  logic      reset,
  input  read_tag_t in_tag,
  output read_tag_t out_tag,
  output logic      scan_inflight
);

  read_tag_t stage [RD_LAT];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= in_tag;
      for (int i = 1; i < RD_LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // The issue register counts as in flight too: it holds a read not yet tagged.
  always_comb begin
    scan_inflight = in_tag.valid && (in_tag.owner == OWNER_SCAN);
    for (int i = 0; i < RD_LAT; i++) begin
      if (stage[i].valid && (stage[i].owner == OWNER_SCAN)) begin
        scan_inflight = 1'b1;
      end
    end
  end

  assign out_tag = stage[RD_LAT-1];

endmodule

// File: rtl/sample_ram_read_arbiter.sv
// Shares the sample RAM read port between CPU single reads and a circular scan
// sequencer. SAMPLE_RAM_ARB_STRIDE_EN enables a programmable scan stride.
module sample_ram_read_arbiter
  import sample_ram_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int RD_LAT = DEFAULT_RD_LAT
) (
  input  logic clk,
  input  logic reset,
  sample_ram_read_arbiter_if.slave bus
);

  scan_state_t       state;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] scan_step;
  logic [ADDR_W-1:0] start_step;
  logic [ADDR_W:0]   remaining;
  logic              aborted;
  owner_t            issue_owner;
  logic              scan_issue;
  read_tag_t         issue_tag;
  read_tag_t         ret_tag;
  logic              scan_inflight;

`ifdef SAMPLE_RAM_ARB_STRIDE_EN
  always_comb begin
    start_step = (bus.scan_stride == '0) ? ADDR_W'(1) : bus.scan_stride;
  end
`else
  always_comb begin
    start_step = ADDR_W'(1);
  end
`endif

  // CPU wins the port; abort and hold both suppress the scan issue.
  always_comb begin
    scan_issue = (state == ST_SCAN) && !bus.scan_abort && !bus.cpu_req && !bus.scan_hold;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      scan_addr     <= '0;
      scan_step     <= '0;
      remaining     <= '0;
      aborted       <= 1'b0;
      issue_owner   <= OWNER_CPU;
      bus.scan_busy <= 1'b0;
      bus.scan_done <= 1'b0;
      bus.ram_addr  <= '0;
      bus.ram_rden  <= 1'b0;
    end else begin
      bus.scan_done <= 1'b0;
      bus.ram_rden  <= bus.cpu_req || scan_issue;
      if (bus.cpu_req) begin
        bus.ram_addr <= bus.cpu_addr;
        issue_owner  <= OWNER_CPU;
      end else if (scan_issue) begin
        bus.ram_addr <= scan_addr;
        issue_owner  <= OWNER_SCAN;
      end

      case (state)
        ST_IDLE: begin
          if (bus.scan_start) begin
            scan_addr     <= bus.scan_base;
            scan_step     <= start_step;
            remaining     <= bus.scan_len;
            aborted       <= 1'b0;
            bus.scan_busy <= 1'b1;
            state         <= (bus.scan_len == '0) ? ST_DRAIN : ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (bus.scan_abort) begin
            aborted <= 1'b1;
            state   <= ST_DRAIN;
          end else if (scan_issue) begin
            // Natural overflow of the ADDR_W-bit add gives the circular wrap.
            scan_addr <= scan_addr + scan_step;
            remaining <= remaining - 1'b1;
            if (remaining == (ADDR_W+1)'(1)) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (!scan_inflight) begin
            state         <= ST_IDLE;
            bus.scan_busy <= 1'b0;
            bus.scan_done <= !aborted;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.scan_state = state;

  always_comb begin
    issue_tag       = '0;
    issue_tag.valid = bus.ram_rden;
    issue_tag.owner = issue_owner;
  end

  read_tag_pipe #(
    .RD_LAT(RD_LAT)
  ) u_tag_pipe (
    .clk          (clk),
    .reset        (reset),
    .in_tag       (issue_tag),
    .out_tag      (ret_tag),
    .scan_inflight(scan_inflight)
  );

  // Return routing: the tag at the pipe tail names the consumer of ram_rdata.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_rdata       <= '0;
      bus.cpu_rdata_valid <= 1'b0;
      bus.scan_data       <= '0;
      bus.scan_data_valid <= 1'b0;
    end else begin
      bus.cpu_rdata_valid <= 1'b0;
      bus.scan_data_valid <= 1'b0;
      if (ret_tag.valid) begin
        if (ret_tag.owner == OWNER_CPU) begin
          bus.cpu_rdata       <= bus.ram_rdata;
          bus.cpu_rdata_valid <= 1'b1;
        end else begin
          bus.scan_data       <= bus.ram_rdata;
          bus.scan_data_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sample_ram_read_arbiter.sv
// Directed bench for sample_ram_read_arbiter: CPU reads, wrap scan, collision,
// abort, len=0, busy restart, hold, reset mid-scan and (optionally) stride.
module tb_sample_ram_read_arbiter;
  import sample_ram_pkg::*;

  localparam int AW     = 12;
  localparam int DW     = 16;
  localparam int RD_LAT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sample_ram_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sample_ram_read_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD_LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0] mem [4096];
  logic [DW-1:0] ram_pipe [RD_LAT];
  always @(posedge clk) begin
    ram_pipe[0] <= bus.ram_rden ? mem[bus.ram_addr] : 16'h0000;
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign bus.ram_rdata = ram_pipe[RD_LAT-1];

  // ---------------- monitor ----------------
  logic [AW-1:0] issue_q[$];
  logic [DW-1:0] scan_q[$];
  logic [DW-1:0] cpu_q[$];
  int done_cnt, done_cyc, last_scan_cyc, cpu_valid_cyc, busy_fall_cyc;
  logic busy_prev = 1'b0;

  always @(negedge clk) begin
    if (bus.ram_rden) issue_q.push_back(bus.ram_addr);
    if (bus.scan_data_valid) begin
      scan_q.push_back(bus.scan_data);
      last_scan_cyc = cyc;
    end
    if (bus.cpu_rdata_valid) begin
      cpu_q.push_back(bus.cpu_rdata);
      cpu_valid_cyc = cyc;
    end
    if (bus.scan_done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (busy_prev && !bus.scan_busy) busy_fall_cyc = cyc;
    busy_prev = bus.scan_busy;
  end

  // ---------------- scoreboard ----------------
  logic [AW-1:0] exp_addr_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_cpu_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic clear_mon();
    issue_q.delete(); scan_q.delete(); cpu_q.delete();
    exp_addr_q.delete(); exp_q.delete(); exp_cpu_q.delete();
    done_cnt = 0; done_cyc = -1; last_scan_cyc = -1; cpu_valid_cyc = -1; busy_fall_cyc = -1;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_issue_n"}, 32'(issue_q.size()), 32'(exp_addr_q.size()));
    for (int i = 0; i < issue_q.size() && i < exp_addr_q.size(); i++)
      check($sformatf("%s_addr%0d", tag, i), 32'(issue_q[i]), 32'(exp_addr_q[i]));
    check({tag, "_scan_n"}, 32'(scan_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < scan_q.size() && i < exp_q.size(); i++)
      check($sformatf("%s_sdata%0d", tag, i), 32'(scan_q[i]), 32'(exp_q[i]));
    check({tag, "_cpu_n"}, 32'(cpu_q.size()), 32'(exp_cpu_q.size()));
    for (int i = 0; i < cpu_q.size() && i < exp_cpu_q.size(); i++)
      check($sformatf("%s_cdata%0d", tag, i), 32'(cpu_q[i]), 32'(exp_cpu_q[i]));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic cpu_read(input logic [AW-1:0] addr);
    bus.cpu_addr = addr;
    bus.cpu_req  = 1'b1;
    tick();
    bus.cpu_req  = 1'b0;
  endtask

  task automatic start_scan(input logic [AW-1:0] base, input logic [AW:0] len);
    bus.scan_base  = base;
    bus.scan_len   = len;
    bus.scan_start = 1'b1;
    tick();
    bus.scan_start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int n = 0;
    while (bus.scan_busy && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_idle"}, 32'(bus.scan_busy), 32'd0);
    run(2);
  endtask

  task automatic expect_scan(input logic [AW-1:0] a);
    exp_addr_q.push_back(a);
    exp_q.push_back(mem[a]);
  endtask

  // ---------------- stimulus ----------------
  int req_cyc;
  logic [AW-1:0] a;

  initial begin
    reset = 1'b1;
    bus.cpu_addr = '0; bus.cpu_req = 1'b0;
    bus.scan_start = 1'b0; bus.scan_abort = 1'b0; bus.scan_hold = 1'b0;
    bus.scan_base = '0; bus.scan_len = '0;
`ifdef SAMPLE_RAM_ARB_STRIDE_EN
    bus.scan_stride = 12'h001;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = 16'(i) ^ 16'hA500;
    mem[12'h123] = 16'hBEEF;
    mem[12'h800] = 16'hC0DE;
    for (int i = 0; i < RD_LAT; i++) ram_pipe[i] = '0;
    clear_mon();
    run(3);

    check("rst_rden",   32'(bus.ram_rden), 32'd0);
    check("rst_addr",   32'(bus.ram_addr), 32'd0);
    check("rst_busy",   32'(bus.scan_busy), 32'd0);
    check("rst_done",   32'(bus.scan_done), 32'd0);
    check("rst_cdata",  32'(bus.cpu_rdata), 32'd0);
    check("rst_cvalid", 32'(bus.cpu_rdata_valid), 32'd0);
    check("rst_sdata",  32'(bus.scan_data), 32'd0);
    check("rst_svalid", 32'(bus.scan_data_valid), 32'd0);
    check("rst_state",  32'(bus.scan_state), 32'(ST_IDLE));
    reset = 1'b0;
    run(2);

    // CPU-only single read and latency
    clear_mon();
    req_cyc = cyc;
    cpu_read(12'h123);
    run(8);
    exp_addr_q.push_back(12'h123);
    exp_cpu_q.push_back(16'hBEEF);
    compare_all("cpu");
    check("cpu_lat", 32'(cpu_valid_cyc - req_cyc), 32'd4);
    check("cpu_hold", 32'(bus.cpu_rdata), 32'hBEEF);
    check("cpu_vpulse", 32'(bus.cpu_rdata_valid), 32'd0);

    // back-to-back CPU reads, results in issue order
    clear_mon();
    bus.cpu_req = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.cpu_addr = 12'(i);
      tick();
    end
    bus.cpu_req = 1'b0;
    run(8);
    for (int i = 1; i <= 3; i++) begin
      exp_addr_q.push_back(12'(i));
      exp_cpu_q.push_back(16'(i) ^ 16'hA500);
    end
    compare_all("b2b");

    // wrap scan
    clear_mon();
    start_scan(12'hFFE, 13'd4);
    check("wrap_busy", 32'(bus.scan_busy), 32'd1);
    wait_idle("wrap", 100);
    expect_scan(12'hFFE); expect_scan(12'hFFF); expect_scan(12'h000); expect_scan(12'h001);
    compare_all("wrap");
    check("wrap_done_n", 32'(done_cnt), 32'd1);
    check("wrap_done_t", 32'(done_cyc - last_scan_cyc), 32'd1);
    check("wrap_busy_t", 32'(busy_fall_cyc - last_scan_cyc), 32'd1);

    // collision: CPU at the third scan issue
    clear_mon();
    start_scan(12'h010, 13'd8);
    run(2);
    cpu_read(12'h800);
    wait_idle("coll", 100);
    expect_scan(12'h010); expect_scan(12'h011);
    exp_addr_q.push_back(12'h800);
    for (int i = 2; i < 8; i++) begin
      a = 12'h010 + 12'(i);
      expect_scan(a);
    end
    exp_cpu_q.push_back(16'hC0DE);
    compare_all("coll");
    check("coll_done_n", 32'(done_cnt), 32'd1);

    // abort after 5 issues
    clear_mon();
    start_scan(12'h200, 13'd100);
    run(5);
    bus.scan_abort = 1'b1;
    tick();
    bus.scan_abort = 1'b0;
    wait_idle("abort", 100);
    for (int i = 0; i < 5; i++) begin
      a = 12'h200 + 12'(i);
      expect_scan(a);
    end
    compare_all("abort");
    check("abort_done_n", 32'(done_cnt), 32'd0);

    // zero length
    clear_mon();
    start_scan(12'h050, 13'd0);
    wait_idle("len0", 20);
    compare_all("len0");
    check("len0_done_n", 32'(done_cnt), 32'd1);

    // restart while busy is ignored; hold stalls without skipping
    clear_mon();
    start_scan(12'h300, 13'd6);
    tick();
    start_scan(12'h000, 13'd2);
    bus.scan_hold = 1'b1;
    run(3);
    bus.scan_hold = 1'b0;
    wait_idle("busy", 100);
    for (int i = 0; i < 6; i++) begin
      a = 12'h300 + 12'(i);
      expect_scan(a);
    end
    compare_all("busy");
    check("busy_done_n", 32'(done_cnt), 32'd1);

    // full 4096-word pass touches every address once
    clear_mon();
    start_scan(12'h123, 13'd4096);
    wait_idle("full", 5000);
    check("full_issue_n", 32'(issue_q.size()), 32'd4096);
    check("full_scan_n", 32'(scan_q.size()), 32'd4096);
    check("full_first", 32'(issue_q.size() > 0 ? issue_q[0] : 12'h0), 32'h123);
    check("full_last", 32'(issue_q.size() > 4095 ? issue_q[4095] : 12'h0), 32'h122);
    check("full_done_n", 32'(done_cnt), 32'd1);

    // reset mid-scan with scan and CPU reads in flight
    clear_mon();
    start_scan(12'h400, 13'd50);
    run(3);
    cpu_read(12'h123);
    reset = 1'b1;
    #1;
    check("mrst_busy",  32'(bus.scan_busy), 32'd0);
    check("mrst_rden",  32'(bus.ram_rden), 32'd0);
    check("mrst_cdata", 32'(bus.cpu_rdata), 32'd0);
    check("mrst_sdata", 32'(bus.scan_data), 32'd0);
    check("mrst_state", 32'(bus.scan_state), 32'(ST_IDLE));
    run(2);
    clear_mon();
    reset = 1'b0;
    run(10);
    compare_all("mrst");
    check("mrst_done_n", 32'(done_cnt), 32'd0);

`ifdef SAMPLE_RAM_ARB_STRIDE_EN
    clear_mon();
    bus.scan_stride = 12'h400;
    start_scan(12'h000, 13'd5);
    wait_idle("stride", 100);
    expect_scan(12'h000); expect_scan(12'h400); expect_scan(12'h800);
    expect_scan(12'hC00); expect_scan(12'h000);
    compare_all("stride");

    clear_mon();
    bus.scan_stride = 12'h000;
    start_scan(12'h010, 13'd2);
    wait_idle("stride0", 100);
    expect_scan(12'h010); expect_scan(12'h011);
    compare_all("stride0");
    bus.scan_stride = 12'h001;
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
